dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits; mask width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_req/m0_we  input  1/1  core (LSU) access request / write-not-read.
REQ-006 m0_addr, m0_wdata, m0_mask  input  ADDR_W, DATA_W, DATA_W/8  core access fields.
REQ-007 m0_gnt, m0_rvalid  output  1/1  core access accepted / core read data valid.
REQ-008 m0_rdata  output  DATA_W  core read data.
REQ-009 m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_gnt, m1_rvalid, m1_rdata: second requester (DMA/debug), same widths and meanings as m0_*.
REQ-010 mem_cs, mem_rd_en, mem_wr_en  output  1 each  data-memory chip select, read enable, write enable.
REQ-011 mem_addr, mem_wdata, mem_mask  output  ADDR_W, DATA_W, DATA_W/8  data-memory command fields.
REQ-012 mem_rdata  input  DATA_W  combinational read data from the data memory.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP; at most one memory access SHALL be in flight.
REQ-014 IDLE: if any mX_req is high, the arbiter SHALL pick a winner and register owner, we, addr, wdata and mask into a command register, then go to ACCESS; otherwise it stays in IDLE.
REQ-015 ACCESS: the arbiter SHALL drive mem_cs=1, mem_wr_en=we, mem_rd_en=!we and the command-register fields, and SHALL pulse the owner's gnt for exactly this cycle.
REQ-016 ACCESS: a write SHALL go to IDLE next; a read SHALL capture mem_rdata into the owner's rdata register at the clock edge and go to RESP.
REQ-017 RESP: the arbiter SHALL hold the owner's rvalid high for exactly one cycle, keep mem_cs/rd_en/wr_en low, and then go to IDLE.
REQ-018 Latency: a write SHALL be granted 1 cycle after it is sampled; read data SHALL be valid 2 cycles after it is sampled.
REQ-019 Requesters SHALL hold req and fields stable until gnt and SHALL drop or replace req in the cycle after gnt (write) or rvalid (read); the core stalls its PC while m0_req is high and it is not yet done.
REQ-020 Requests present in ACCESS or RESP SHALL be ignored until IDLE; a req dropped after it is sampled SHALL NOT abort the access.
REQ-021 mX_rdata SHALL hold its last captured value until that requester's next read response.
REQ-022 Outside ACCESS, mem_cs, mem_rd_en and mem_wr_en SHALL be 0; gnt and rvalid SHALL never be high for both requesters in the same cycle.
REQ-023 Address, mask and alignment SHALL pass through unmodified; no error signalling.

Reset
REQ-024 While reset is low: state=IDLE; all gnt, rvalid and mem_* enables are 0; command register, rdata registers and last_owner=1 (so m0 wins the first tie).
REQ-025 Reset asserted during ACCESS or RESP SHALL immediately deassert mem_wr_en and mem_cs and discard the access; no gnt or rvalid SHALL follow.

Configuration
REQ-026 With DMEM_ARB_RR_EN defined: on a tie the arbiter SHALL grant the requester that is not last_owner, and last_owner SHALL update at every IDLE->ACCESS transition.
REQ-027 Without DMEM_ARB_RR_EN: fixed priority, m0 SHALL always win a tie, and there SHALL be no last_owner register.

Structure
REQ-028 Package dmem_arb_pkg SHALL hold the state enum, the owner typedef (M0/M1) and the default width constants.
REQ-029 Sub-module arb_pick2 SHALL be the combinational 2-way picker (req0, req1, last_owner -> winner); it is instanced once.

Verification
REQ-030 m0 read addr 0x10 alone, mem_rdata=0xDEADBEEF -> m0_gnt at cycle+1, m0_rvalid and m0_rdata=0xDEADBEEF at cycle+2, state IDLE at cycle+3.
REQ-031 m1 write addr 0x20, wdata 0x12345678, mask 4'b0011 -> one ACCESS cycle with mem_wr_en=1 and matching fields, m1_gnt pulse, no rvalid.
REQ-032 m0 and m1 both held high for 4 accesses, with DMEM_ARB_RR_EN -> grants m0,m1,m0,m1; without it -> m0,m0,m0,m0.
REQ-033 reset pulled low in ACCESS of a write -> mem_wr_en drops immediately, no gnt; after release, a new m0 request completes normally.
REQ-034 m1 asserts req during m0's RESP cycle -> m1 is sampled in the following IDLE and granted one cycle later; m0_rdata stays unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters (core LSU, DMA/debug) and one data memory.
// slave = arbiter view; master = requesters plus memory model view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_W-1:0]     m0_addr;
    logic [DATA_W-1:0]     m0_wdata;
    logic [DATA_W/8-1:0]   m0_mask;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_W-1:0]     m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_W-1:0]     m1_addr;
    logic [DATA_W-1:0]     m1_wdata;
    logic [DATA_W/8-1:0]   m1_mask;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_W-1:0]     m1_rdata;

    logic                  mem_cs;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_mask;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_cs, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_cs, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask,
        output mem_rdata
    );

endinterface

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: a tie goes to whichever requester is not last_owner.
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_e last_owner,
    output owner_e winner
);

    always_comb begin
        winner = M0;
        if (req0 && req1) begin
            winner = (last_owner == M0) ? M1 : M0;
        end else if (req1) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one access in flight (IDLE -> ACCESS [-> RESP]).
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is fixed priority to m0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned MaskW = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MaskW-1:0]    mask_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    owner_e              last_owner;
    owner_e              winner;
    logic                load_cmd;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [MaskW-1:0]    win_mask;
    logic                in_access, in_resp;

`ifdef DMEM_ARB_RR_EN
    owner_e last_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= M1;
        end else if (load_cmd) begin
            last_owner_q <= winner;
        end
    end

    assign last_owner = last_owner_q;
`else
    // Pretending m1 always went last makes the picker favour m0 on every tie.
    assign last_owner = M1;
`endif

    arb_pick2 u_pick (
        .req0       (bus.m0_req),
        .req1       (bus.m1_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    always_comb begin
        win_we    = bus.m0_we;
        win_addr  = bus.m0_addr;
        win_wdata = bus.m0_wdata;
        win_mask  = bus.m0_mask;
        if (winner == M1) begin
            win_we    = bus.m1_we;
            win_addr  = bus.m1_addr;
            win_wdata = bus.m1_wdata;
            win_mask  = bus.m1_mask;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d  = StAccess;
                    load_cmd = 1'b1;
                end
            end
            StAccess: state_d = we_q ? StIdle : StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            owner_q  <= M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_cmd) begin
                owner_q <= winner;
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                mask_q  <= win_mask;
            end
            if (in_access && !we_q) begin
                if (owner_q == M0) begin
                    rdata0_q <= bus.mem_rdata;
                end else begin
                    rdata1_q <= bus.mem_rdata;
                end
            end
        end
    end

    // All strobes decode from the async-reset state, so reset kills them at once.
    assign in_access = (state_q == StAccess);
    assign in_resp   = (state_q == StResp);

    assign bus.mem_cs    = in_access;
    assign bus.mem_wr_en = in_access && we_q;
    assign bus.mem_rd_en = in_access && !we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;

    assign bus.m0_gnt    = in_access && (owner_q == M0);
    assign bus.m1_gnt    = in_access && (owner_q == M1);
    assign bus.m0_rvalid = in_resp && (owner_q == M0);
    assign bus.m1_rvalid = in_resp && (owner_q == M1);
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; inputs driven and outputs sampled on negedge.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_cs"}, 64'(bus.mem_cs), 64'd0);
        check_eq({tag, "_gnt"}, 64'({bus.m0_gnt, bus.m1_gnt}), 64'd0);
        check_eq({tag, "_rv"}, 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
    endtask

    int unsigned exp_own [4];
    int unsigned got_own [4];
    int unsigned n_gnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m0_mask = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.m1_mask = '0;
        bus.mem_rdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();

        // Reset state
        check_quiet("rst");
        check_eq("rst_state", 64'(dut.state_q), 64'(StIdle));
        check_eq("rst_rdata0", 64'(bus.m0_rdata), 64'd0);
        check_eq("rst_addr", 64'(bus.mem_addr), 64'd0);
        reset = 1'b1;
        tick();
        check_quiet("idle0");

        // m0 read of 0x10
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        check_eq("rd_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b10);
        check_eq("rd_en", 64'({bus.mem_cs, bus.mem_rd_en, bus.mem_wr_en}), 64'b110);
        check_eq("rd_addr", 64'(bus.mem_addr), 64'h10);
        tick();
        check_eq("rd_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'b10);
        check_eq("rd_data", 64'(bus.m0_rdata), 64'hDEADBEEF);
        check_eq("rd_resp_cs", 64'(bus.mem_cs), 64'd0);
        bus.m0_req = 1'b0;
        tick();
        check_eq("rd_idle", 64'(dut.state_q), 64'(StIdle));
        check_quiet("rd_after");

        // m1 write
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20;
        bus.m1_wdata = 32'h12345678; bus.m1_mask = 4'b0011;
        tick();
        check_eq("wr_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b01);
        check_eq("wr_en", 64'({bus.mem_cs, bus.mem_rd_en, bus.mem_wr_en}), 64'b101);
        check_eq("wr_addr", 64'(bus.mem_addr), 64'h20);
        check_eq("wr_wdata", 64'(bus.mem_wdata), 64'h12345678);
        check_eq("wr_mask", 64'(bus.mem_mask), 64'h3);
        check_eq("wr_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        bus.m1_req = 1'b0;
        tick();
        check_quiet("wr_after");

        // Tie: both write requests held for 4 grants
`ifdef DMEM_ARB_RR_EN
        exp_own = '{0, 1, 0, 1};
`else
        exp_own = '{0, 0, 0, 0};
`endif
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h100; bus.m0_mask = 4'hF;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h200; bus.m1_mask = 4'hF;
        n_gnt = 0;
        for (int i = 0; i < 12 && n_gnt < 4; i++) begin
            tick();
            check_eq("tie_excl", 64'(bus.m0_gnt & bus.m1_gnt), 64'd0);
            if (bus.m0_gnt || bus.m1_gnt) begin
                got_own[n_gnt] = bus.m1_gnt ? 1 : 0;
                n_gnt++;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        check_eq("tie_count", 64'(n_gnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("tie_own%0d", i), 64'(got_own[i]), 64'(exp_own[i]));
        end
        tick();
        check_quiet("tie_after");

        // Reset during a write's ACCESS cycle
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h300;
        tick();
        check_eq("rw_pre", 64'(bus.mem_wr_en), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rw_wr_en", 64'({bus.mem_cs, bus.mem_wr_en}), 64'd0);
        check_eq("rw_gnt", 64'(bus.m0_gnt), 64'd0);
        bus.m0_req = 1'b0;
        tick();
        check_quiet("rw_held");
        reset = 1'b1;
        tick();
        check_quiet("rw_rel");
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h44;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        check_eq("rw_new_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b10);
        check_eq("rw_new_addr", 64'(bus.mem_addr), 64'h44);
        tick();
        check_eq("rw_new_rv", 64'(bus.m0_rvalid), 64'd1);
        check_eq("rw_new_data", 64'(bus.m0_rdata), 64'hCAFEF00D);
        bus.m0_req = 1'b0;
        tick();

        // m1 arrives during m0's RESP
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h30;
        bus.mem_rdata = 32'h11112222;
        tick();
        check_eq("ov_gnt0", 64'(bus.m0_gnt), 64'd1);
        tick();
        check_eq("ov_rv0", 64'(bus.m0_rvalid), 64'd1);
        check_eq("ov_data0", 64'(bus.m0_rdata), 64'h11112222);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h40;
        bus.mem_rdata = 32'h99999999;
        tick();
        check_quiet("ov_idle");
        tick();
        check_eq("ov_gnt1", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b01);
        check_eq("ov_addr1", 64'(bus.mem_addr), 64'h40);
        check_eq("ov_hold0", 64'(bus.m0_rdata), 64'h11112222);
        bus.m1_req = 1'b0;
        tick();
        check_quiet("ov_after");
        check_eq("ov_hold0b", 64'(bus.m0_rdata), 64'h11112222);
        check_eq("ov_rdata1", 64'(bus.m1_rdata), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
